mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares the single byte-wide RAM port between instruction fetch (IF) and the load/store requests the EX stage forwards to MEM.
Accepts one request at a time and serialises it into 1/2/4 little-endian byte accesses. Load data is sign- or zero-extended, and the block acks the requester.
Raises stall_req_o so the pipeline holds while a MEM access is pending.

Parameters:
ADDR_W, 32, byte address width (matches InstAddrBus)
RD_LAT, 1, RAM read latency in cycles; only 1 is supported

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset; one clock, reset asynchronous and active-low
if_req_i  in  1  fetch request, held with if_addr_i until if_ack_o
if_addr_i  in  ADDR_W  fetch address
if_ack_o  out  1  one-cycle pulse; if_inst_o valid
if_inst_o  out  32  fetched word, held until the next fetch ack
me_req_i  in  1  MEM request, held with the other me_* inputs until me_ack_o
me_aluop_i  in  AluOpBus  EX_LB/LH/LW/LBU/LHU/SB/SH/SW_OP or ME_NOP_OP
me_addr_i  in  ADDR_W  load/store address
me_wdata_i  in  32  store data (low bytes used)
me_ack_o  out  1  one-cycle pulse; access complete, me_rdata_o valid for loads
me_rdata_o  out  32  extended load data, held until the next load ack
stall_req_o  out  1  pipeline stall request
ram_addr_o  out  ADDR_W  RAM byte address
ram_wr_o  out  1  RAM write strobe
ram_wdata_o  out  8  RAM write byte
ram_rdata_i  in  8  RAM read byte; registered, valid the cycle after its address is issued

Behaviour:
- Reset (async, rst_n=0): state IDLE, byte counter 0. All outputs are 0, including if_inst_o and me_rdata_o.
- Reset mid-transfer abandons the access with no ack. Bytes already written stay written.
- Valid MEM request: me_req_i=1 and me_aluop_i is a load/store op. Any other op is ignored: no ack, no stall.
- Byte count n: LB/LBU/SB=1, LH/LHU/SH=2, LW/SW/fetch=4.
- No alignment check. Byte k goes to addr+k, wrapping modulo 2^ADDR_W.
- FSM states: IDLE, XFER, WAIT, DONE.
- IDLE: a valid MEM request wins over if_req_i. The winner's op, address and data are latched at the edge, cnt=0, next state XFER.
- XFER: ram_addr_o = latched addr + cnt.
  - Stores: ram_wr_o=1, ram_wdata_o = wdata byte cnt.
  - After cnt reaches n-1: stores go to DONE, loads and fetches go to WAIT.
- Read capture: ram_rdata_i in XFER cycles cnt 1..n-1 and in the WAIT cycle is stored as byte cnt-1 (respectively n-1).
- WAIT: one cycle, captures the last byte, next state DONE.
- DONE: the winner's ack is 1 for exactly this cycle with its data valid; next state IDLE.
- Latency from the accepting edge to the ack cycle: read n+2 cycles (LW=6, LB=3); write n+1 cycles (SW=5, SB=2).
- Load extension: LB sign-extends bit 7, LH sign-extends bit 15, LBU/LHU zero-extend. LW and fetch are unchanged.
- Address output: ram_addr_o=0 and ram_wr_o=0 outside XFER.
- No preemption: a MEM request arriving during a fetch waits; the fetch completes first.
- Both requests in the same IDLE cycle: MEM is served first, fetch on a later IDLE.
- Requesters see the ack at the end of DONE. The next IDLE cycle therefore samples fresh request lines, so a held request is never double-served.
- stall_req_o = valid MEM request & ~me_ack_o (combinational). It is high during any foreign fetch too and low in the ack cycle.

Decomposition:
- Shared defines (Defines.vh / ALUInstDef.vh): FSM state encodings, ME op-class decode (is_load/is_store), byte-count constants.
- One combinational sub-module, load_extend: latched op plus 32-bit assembled bytes in, extended me_rdata out.

Test Plan:
RAM[0x100..0x103] = 80,12,34,F6.
- if_req_i with addr 0x100 -> if_ack_o 6 cycles after accept; if_inst_o=0xF6341280; stall_req_o stays 0.
- LB at 0x100 -> ack at 3 cycles, rdata 0xFFFFFF80.
  - LBU -> 0x00000080.
  - LH at 0x102 -> 0xFFFFF634.
  - LHU at 0x100 -> 0x00001280.
- SH at 0x200 with wdata 0xDEADBEEF -> writes EF@0x200 then BE@0x201; ack at 3 cycles; 0x202 untouched.
- if_req_i and SW both raised in the same cycle -> SW served first, stall_req_o high until me_ack_o; then the fetch is acked.
- SW raised during the fetch's XFER -> fetch completes and is acked, then SW runs; stall_req_o stays high throughout.
- rst_n dropped after 2 bytes of SW at 0x300 -> all outputs 0 immediately, no ack.
  - After release: only bytes 0x300/0x301 were written, state IDLE.
  - me_req_i with ME_NOP_OP -> ignored, stall_req_o=0.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the byte-wide RAM port arbiter: FSM states, ME op codes,
// op-class decode and byte-count helpers.
package mem_port_arbiter_pkg;

   localparam int ALU_OP_W = 8;
   typedef logic [ALU_OP_W-1:0] alu_op_t;

   localparam alu_op_t ME_NOP_OP = 8'h00;
   localparam alu_op_t EX_LB_OP  = 8'h20;
   localparam alu_op_t EX_LH_OP  = 8'h21;
   localparam alu_op_t EX_LW_OP  = 8'h23;
   localparam alu_op_t EX_LBU_OP = 8'h24;
   localparam alu_op_t EX_LHU_OP = 8'h25;
   localparam alu_op_t EX_SB_OP  = 8'h28;
   localparam alu_op_t EX_SH_OP  = 8'h29;
   localparam alu_op_t EX_SW_OP  = 8'h2B;

   // Index of the final byte of an access (byte count minus one)
   localparam logic [1:0] LAST_BYTE_B = 2'd0;
   localparam logic [1:0] LAST_BYTE_H = 2'd1;
   localparam logic [1:0] LAST_BYTE_W = 2'd3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_t;

   function automatic logic is_load(input alu_op_t op);
      return (op == EX_LB_OP) || (op == EX_LH_OP) || (op == EX_LW_OP) ||
             (op == EX_LBU_OP) || (op == EX_LHU_OP);
   endfunction

   function automatic logic is_store(input alu_op_t op);
      return (op == EX_SB_OP) || (op == EX_SH_OP) || (op == EX_SW_OP);
   endfunction

   function automatic logic [1:0] last_byte(input alu_op_t op);
      logic [1:0] idx;
      case (op)
         EX_LB_OP, EX_LBU_OP, EX_SB_OP: idx = LAST_BYTE_B;
         EX_LH_OP, EX_LHU_OP, EX_SH_OP: idx = LAST_BYTE_H;
         default:                       idx = LAST_BYTE_W;
      endcase
      return idx;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and RAM-side signals of the arbiter; slave is the arbiter's view.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32
);
   import mem_port_arbiter_pkg::*;

   logic              if_req_i;
   logic [ADDR_W-1:0] if_addr_i;
   logic              if_ack_o;
   logic [31:0]       if_inst_o;
   logic              me_req_i;
   alu_op_t           me_aluop_i;
   logic [ADDR_W-1:0] me_addr_i;
   logic [31:0]       me_wdata_i;
   logic              me_ack_o;
   logic [31:0]       me_rdata_o;
   logic              stall_req_o;
   logic [ADDR_W-1:0] ram_addr_o;
   logic              ram_wr_o;
   logic [7:0]        ram_wdata_o;
   logic [7:0]        ram_rdata_i;

   modport slave (
      input  if_req_i, if_addr_i, me_req_i, me_aluop_i, me_addr_i, me_wdata_i, ram_rdata_i,
      output if_ack_o, if_inst_o, me_ack_o, me_rdata_o, stall_req_o,
             ram_addr_o, ram_wr_o, ram_wdata_o
   );

   modport master (
      output if_req_i, if_addr_i, me_req_i, me_aluop_i, me_addr_i, me_wdata_i, ram_rdata_i,
      input  if_ack_o, if_inst_o, me_ack_o, me_rdata_o, stall_req_o,
             ram_addr_o, ram_wr_o, ram_wdata_o
   );

endinterface

// File: rtl/mem_port_arbiter_load_extend.sv
// Sign/zero extension of assembled load bytes according to the latched op.
module mem_port_arbiter_load_extend
   import mem_port_arbiter_pkg::*;
(
   input  alu_op_t     op,
   input  logic [31:0] raw,
   output logic [31:0] ext
);

   always_comb begin
      ext = raw;
      case (op)
         EX_LB_OP:  ext = {{24{raw[7]}}, raw[7:0]};
         EX_LBU_OP: ext = {24'h000000, raw[7:0]};
         EX_LH_OP:  ext = {{16{raw[15]}}, raw[15:0]};
         EX_LHU_OP: ext = {16'h0000, raw[15:0]};
         default:   ext = raw;
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises one fetch or MEM load/store at a time onto a byte-wide RAM port,
// little-endian, MEM having priority at IDLE and no preemption once started.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int RD_LAT = 1
) (
   input logic clk,
   input logic rst_n,
   mem_port_arbiter_if.slave bus
);

   generate
      if (RD_LAT != 1) begin : g_rd_lat_check
         $error("mem_port_arbiter supports only RD_LAT == 1");
      end
   endgenerate

   state_t            state, state_nxt;
   logic [1:0]        cnt, last_q, prev_idx;
   logic [ADDR_W-1:0] addr_q, ram_addr;
   logic [3:0][7:0]   wdata_q, rbuf;
   alu_op_t           op_q;
   logic              fetch_q, me_valid, if_ack, me_ack, ram_wr;
   logic [7:0]        ram_wdata;
   logic [31:0]       rdata_ext, if_inst_q, me_rdata_q;

   assign me_valid = bus.me_req_i & (is_load(bus.me_aluop_i) | is_store(bus.me_aluop_i));
   assign prev_idx = cnt - 2'd1;

   always_comb begin
      state_nxt = state;
      ram_addr  = '0;
      ram_wr    = 1'b0;
      ram_wdata = 8'h00;
      if_ack    = 1'b0;
      me_ack    = 1'b0;
      case (state)
         IDLE: if (me_valid || bus.if_req_i) state_nxt = XFER;
         XFER: begin
            ram_addr = addr_q + ADDR_W'(cnt);
            ram_wr   = is_store(op_q);
            if (ram_wr) ram_wdata = wdata_q[cnt];
            if (cnt == last_q) state_nxt = is_store(op_q) ? DONE : WAIT;
         end
         WAIT: state_nxt = DONE;
         DONE: begin
            if_ack    = fetch_q;
            me_ack    = ~fetch_q;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Fetches reuse the LW path; fetch_q only steers the ack and result register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= 2'd0;
         last_q     <= 2'd0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rbuf       <= '0;
         op_q       <= ME_NOP_OP;
         fetch_q    <= 1'b0;
         if_inst_q  <= 32'h0;
         me_rdata_q <= 32'h0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               cnt  <= 2'd0;
               rbuf <= '0;
               if (me_valid) begin
                  op_q    <= bus.me_aluop_i;
                  addr_q  <= bus.me_addr_i;
                  wdata_q <= bus.me_wdata_i;
                  last_q  <= last_byte(bus.me_aluop_i);
                  fetch_q <= 1'b0;
               end else if (bus.if_req_i) begin
                  op_q    <= EX_LW_OP;
                  addr_q  <= bus.if_addr_i;
                  wdata_q <= '0;
                  last_q  <= LAST_BYTE_W;
                  fetch_q <= 1'b1;
               end
            end
            XFER: begin
               cnt <= cnt + 2'd1;
               if (cnt != 2'd0) rbuf[prev_idx] <= bus.ram_rdata_i;
            end
            WAIT: rbuf[last_q] <= bus.ram_rdata_i;
            DONE: begin
               if (fetch_q) if_inst_q <= rbuf;
               else if (is_load(op_q)) me_rdata_q <= rdata_ext;
            end
            default: ;
         endcase
      end
   end

   mem_port_arbiter_load_extend u_load_extend (
      .op  (op_q),
      .raw (rbuf),
      .ext (rdata_ext)
   );

   // Results bypass their hold registers during the ack cycle
   assign bus.if_ack_o    = if_ack;
   assign bus.me_ack_o    = me_ack;
   assign bus.if_inst_o   = if_ack ? rbuf : if_inst_q;
   assign bus.me_rdata_o  = (me_ack && is_load(op_q)) ? rdata_ext : me_rdata_q;
   assign bus.stall_req_o = rst_n & me_valid & ~me_ack;
   assign bus.ram_addr_o  = ram_addr;
   assign bus.ram_wr_o    = ram_wr;
   assign bus.ram_wdata_o = ram_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a registered byte-RAM model.
module tb_mem_port_arbiter;
   import mem_port_arbiter_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   failed = 0;

   always #5 clk = ~clk;

   mem_port_arbiter_if #(.ADDR_W(32)) bus ();

   mem_port_arbiter #(.ADDR_W(32), .RD_LAT(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   logic [7:0] mem [0:1023];

   // Byte RAM: write strobe at the edge, registered read of the issued address
   always @(posedge clk) begin
      if (bus.ram_wr_o) mem[bus.ram_addr_o[9:0]] <= bus.ram_wdata_o;
      bus.ram_rdata_i <= mem[bus.ram_addr_o[9:0]];
   end

   task automatic idle_inputs();
      bus.if_req_i   = 1'b0;
      bus.if_addr_i  = 32'h0;
      bus.me_req_i   = 1'b0;
      bus.me_aluop_i = ME_NOP_OP;
      bus.me_addr_i  = 32'h0;
      bus.me_wdata_i = 32'h0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if ({bus.if_ack_o, bus.me_ack_o, bus.stall_req_o, bus.ram_wr_o} !== 4'b0000) begin
         failed++;
         $display("[TB] FAIL reset_flags: got %b expected 0000",
                  {bus.if_ack_o, bus.me_ack_o, bus.stall_req_o, bus.ram_wr_o});
      end
      tests++;
      if ({bus.ram_addr_o, bus.ram_wdata_o, bus.if_inst_o, bus.me_rdata_o} !== 104'h0) begin
         failed++;
         $display("[TB] FAIL reset_data: got %h expected 0",
                  {bus.ram_addr_o, bus.ram_wdata_o, bus.if_inst_o, bus.me_rdata_o});
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_fetch();
      int  k;
      bit  stall_seen;
      k = 0;
      stall_seen = 1'b0;
      bus.if_addr_i = 32'h100;
      bus.if_req_i  = 1'b1;
      do begin
         @(posedge clk);
         #1;
         k++;
         if (bus.stall_req_o) stall_seen = 1'b1;
      end while (!bus.if_ack_o && k < 20);
      tests++;
      if (k !== 6) begin
         failed++;
         $display("[TB] FAIL fetch_latency: got %0d expected 6", k);
      end
      tests++;
      if (bus.if_inst_o !== 32'hF6341280) begin
         failed++;
         $display("[TB] FAIL fetch_data: got %h expected F6341280", bus.if_inst_o);
      end
      tests++;
      if (stall_seen !== 1'b0) begin
         failed++;
         $display("[TB] FAIL fetch_no_stall: got %b expected 0", stall_seen);
      end
      bus.if_req_i = 1'b0;
      @(posedge clk);
      #1;
      tests++;
      if ({bus.if_ack_o, bus.if_inst_o} !== {1'b0, 32'hF6341280}) begin
         failed++;
         $display("[TB] FAIL fetch_hold: got %h expected 0F6341280", {bus.if_ack_o, bus.if_inst_o});
      end
   endtask

   task automatic test_loads();
      alu_op_t     op_t  [5] = '{EX_LB_OP, EX_LBU_OP, EX_LH_OP, EX_LHU_OP, EX_LW_OP};
      logic [31:0] adr_t [5] = '{32'h100, 32'h100, 32'h102, 32'h100, 32'h100};
      logic [31:0] exp_t [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFFF634, 32'h00001280, 32'hF6341280};
      int          lat_t [5] = '{3, 3, 4, 4, 6};
      int          k;
      for (int i = 0; i < 5; i++) begin
         bus.me_aluop_i = op_t[i];
         bus.me_addr_i  = adr_t[i];
         bus.me_req_i   = 1'b1;
         #1;
         tests++;
         if (bus.stall_req_o !== 1'b1) begin
            failed++;
            $display("[TB] FAIL load%0d_stall_req: got %b expected 1", i, bus.stall_req_o);
         end
         k = 0;
         do begin
            @(posedge clk);
            #1;
            k++;
         end while (!bus.me_ack_o && k < 20);
         tests++;
         if (k !== lat_t[i]) begin
            failed++;
            $display("[TB] FAIL load%0d_latency: got %0d expected %0d", i, k, lat_t[i]);
         end
         tests++;
         if (bus.me_rdata_o !== exp_t[i]) begin
            failed++;
            $display("[TB] FAIL load%0d_data: got %h expected %h", i, bus.me_rdata_o, exp_t[i]);
         end
         tests++;
         if (bus.stall_req_o !== 1'b0) begin
            failed++;
            $display("[TB] FAIL load%0d_ack_stall: got %b expected 0", i, bus.stall_req_o);
         end
         bus.me_req_i = 1'b0;
         @(posedge clk);
         #1;
      end
      tests++;
      if (bus.me_rdata_o !== 32'hF6341280) begin
         failed++;
         $display("[TB] FAIL load_hold: got %h expected F6341280", bus.me_rdata_o);
      end
   endtask

   task automatic test_store_half();
      int k;
      k = 0;
      bus.me_aluop_i = EX_SH_OP;
      bus.me_addr_i  = 32'h200;
      bus.me_wdata_i = 32'hDEADBEEF;
      bus.me_req_i   = 1'b1;
      do begin
         @(posedge clk);
         #1;
         k++;
      end while (!bus.me_ack_o && k < 20);
      tests++;
      if (k !== 3) begin
         failed++;
         $display("[TB] FAIL sh_latency: got %0d expected 3", k);
      end
      bus.me_req_i = 1'b0;
      @(posedge clk);
      #1;
      tests++;
      if ({mem[10'h200], mem[10'h201], mem[10'h202]} !== 24'hEFBE00) begin
         failed++;
         $display("[TB] FAIL sh_bytes: got %h expected EFBE00",
                  {mem[10'h200], mem[10'h201], mem[10'h202]});
      end
      tests++;
      if (bus.me_rdata_o !== 32'hF6341280) begin
         failed++;
         $display("[TB] FAIL sh_rdata_hold: got %h expected F6341280", bus.me_rdata_o);
      end
   endtask

   task automatic test_back_to_back();
      int k;
      bit early_fetch_ack;
      bit stall_drop;
      k = 0;
      early_fetch_ack = 1'b0;
      stall_drop = 1'b0;
      bus.if_addr_i  = 32'h100;
      bus.if_req_i   = 1'b1;
      bus.me_aluop_i = EX_SW_OP;
      bus.me_addr_i  = 32'h400;
      bus.me_wdata_i = 32'h11223344;
      bus.me_req_i   = 1'b1;
      do begin
         @(posedge clk);
         #1;
         k++;
         if (bus.if_ack_o) early_fetch_ack = 1'b1;
         if (!bus.me_ack_o && !bus.stall_req_o) stall_drop = 1'b1;
      end while (!bus.me_ack_o && k < 20);
      tests++;
      if (k !== 5) begin
         failed++;
         $display("[TB] FAIL both_sw_latency: got %0d expected 5", k);
      end
      tests++;
      if ({early_fetch_ack, stall_drop} !== 2'b00) begin
         failed++;
         $display("[TB] FAIL both_sw_first: got %b expected 00", {early_fetch_ack, stall_drop});
      end
      bus.me_req_i = 1'b0;
      k = 0;
      do begin
         @(posedge clk);
         #1;
         k++;
      end while (!bus.if_ack_o && k < 20);
      tests++;
      if (k !== 7) begin
         failed++;
         $display("[TB] FAIL both_fetch_after: got %0d expected 7", k);
      end
      tests++;
      if (bus.if_inst_o !== 32'hF6341280) begin
         failed++;
         $display("[TB] FAIL both_fetch_data: got %h expected F6341280", bus.if_inst_o);
      end
      bus.if_req_i = 1'b0;
      @(posedge clk);
      #1;
      tests++;
      if ({mem[10'h400], mem[10'h401], mem[10'h402], mem[10'h403]} !== 32'h44332211) begin
         failed++;
         $display("[TB] FAIL both_sw_bytes: got %h expected 44332211",
                  {mem[10'h400], mem[10'h401], mem[10'h402], mem[10'h403]});
      end
   endtask

   task automatic test_no_preempt();
      int k;
      bit stall_drop;
      k = 0;
      stall_drop = 1'b0;
      bus.if_addr_i = 32'h100;
      bus.if_req_i  = 1'b1;
      do begin
         @(posedge clk);
         #1;
         k++;
         if (k == 2) begin
            bus.me_aluop_i = EX_SW_OP;
            bus.me_addr_i  = 32'h500;
            bus.me_wdata_i = 32'hA1B2C3D4;
            bus.me_req_i   = 1'b1;
         end else if (k > 2 && !bus.stall_req_o) begin
            stall_drop = 1'b1;
         end
      end while (!bus.if_ack_o && k < 20);
      tests++;
      if (k !== 6) begin
         failed++;
         $display("[TB] FAIL preempt_fetch_latency: got %0d expected 6", k);
      end
      tests++;
      if (bus.if_inst_o !== 32'hF6341280) begin
         failed++;
         $display("[TB] FAIL preempt_fetch_data: got %h expected F6341280", bus.if_inst_o);
      end
      bus.if_req_i = 1'b0;
      k = 0;
      do begin
         @(posedge clk);
         #1;
         k++;
         if (!bus.me_ack_o && !bus.stall_req_o) stall_drop = 1'b1;
      end while (!bus.me_ack_o && k < 20);
      tests++;
      if (k !== 6) begin
         failed++;
         $display("[TB] FAIL preempt_sw_latency: got %0d expected 6", k);
      end
      tests++;
      if (stall_drop !== 1'b0) begin
         failed++;
         $display("[TB] FAIL preempt_stall_held: got %b expected 0", stall_drop);
      end
      bus.me_req_i = 1'b0;
      @(posedge clk);
      #1;
      tests++;
      if ({mem[10'h500], mem[10'h501], mem[10'h502], mem[10'h503]} !== 32'hD4C3B2A1) begin
         failed++;
         $display("[TB] FAIL preempt_sw_bytes: got %h expected D4C3B2A1",
                  {mem[10'h500], mem[10'h501], mem[10'h502], mem[10'h503]});
      end
   endtask

   task automatic test_reset_mid();
      bit ack_seen;
      ack_seen = 1'b0;
      bus.me_aluop_i = EX_SW_OP;
      bus.me_addr_i  = 32'h300;
      bus.me_wdata_i = 32'hCAFEBABE;
      bus.me_req_i   = 1'b1;
      repeat (3) begin
         @(posedge clk);
         #1;
         if (bus.me_ack_o) ack_seen = 1'b1;
      end
      rst_n = 1'b0;
      #1;
      tests++;
      if ({bus.if_ack_o, bus.me_ack_o, bus.stall_req_o, bus.ram_wr_o, bus.ram_addr_o,
           bus.ram_wdata_o, bus.if_inst_o, bus.me_rdata_o} !== 108'h0) begin
         failed++;
         $display("[TB] FAIL midreset_outputs: got %h expected 0",
                  {bus.if_ack_o, bus.me_ack_o, bus.stall_req_o, bus.ram_wr_o, bus.ram_addr_o,
                   bus.ram_wdata_o, bus.if_inst_o, bus.me_rdata_o});
      end
      bus.me_req_i = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
         if (bus.me_ack_o) ack_seen = 1'b1;
      end
      rst_n = 1'b1;
      repeat (4) begin
         @(posedge clk);
         #1;
         if (bus.me_ack_o) ack_seen = 1'b1;
      end
      tests++;
      if (ack_seen !== 1'b0) begin
         failed++;
         $display("[TB] FAIL midreset_no_ack: got %b expected 0", ack_seen);
      end
      tests++;
      if ({mem[10'h300], mem[10'h301], mem[10'h302], mem[10'h303]} !== 32'hBEBA0000) begin
         failed++;
         $display("[TB] FAIL midreset_bytes: got %h expected BEBA0000",
                  {mem[10'h300], mem[10'h301], mem[10'h302], mem[10'h303]});
      end
      tests++;
      if (dut.state !== IDLE) begin
         failed++;
         $display("[TB] FAIL midreset_state: got %0d expected %0d", dut.state, IDLE);
      end
   endtask

   task automatic test_nop();
      bit activity;
      activity = 1'b0;
      bus.me_aluop_i = ME_NOP_OP;
      bus.me_addr_i  = 32'h100;
      bus.me_req_i   = 1'b1;
      #1;
      tests++;
      if (bus.stall_req_o !== 1'b0) begin
         failed++;
         $display("[TB] FAIL nop_stall: got %b expected 0", bus.stall_req_o);
      end
      repeat (6) begin
         @(posedge clk);
         #1;
         if (bus.me_ack_o || bus.stall_req_o || bus.ram_wr_o || bus.ram_addr_o != 32'h0)
            activity = 1'b1;
      end
      tests++;
      if (activity !== 1'b0) begin
         failed++;
         $display("[TB] FAIL nop_ignored: got %b expected 0", activity);
      end
      bus.me_req_i = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
      mem[10'h100] <= 8'h80;
      mem[10'h101] <= 8'h12;
      mem[10'h102] <= 8'h34;
      mem[10'h103] <= 8'hF6;
      #1;
      test_reset();
      test_fetch();
      test_loads();
      test_store_half();
      test_back_to_back();
      test_no_preempt();
      test_reset_mid();
      test_nop();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
